// File: rtl/parking_pkg.sv
// Shared widths, limits and state encoding for the parking meter session logic.
package parking_pkg;
    localparam int SEC_W      = 12;
    localparam int COST_W     = 14;
    localparam int CFG_W      = 8;
    localparam int ADD_STEP   = 300;
    localparam int MAX_SEC    = 3599;
    localparam int HOUR_LIMIT = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_RUN     = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;
endpackage

// File: rtl/session_timer.sv
// Purchased/remaining-time counter: clear, saturating add of a fixed step, decrement-to-zero.
module session_timer #(
    parameter int W    = 12,
    parameter int STEP = 300,
    parameter int MAX  = 3599
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         add,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero_next
);
    localparam logic [W:0] STEP_W = (W+1)'(STEP);
    localparam logic [W:0] MAX_W  = (W+1)'(MAX);

    logic [W:0] sum;

    // One extra bit so the add cannot wrap before saturation.
    always_comb sum = {1'b0, count} + STEP_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (add)
            count <= (sum > MAX_W) ? MAX_W[W-1:0] : sum[W-1:0];
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero_next = (count == W'(1));
endmodule

// File: rtl/parking_session_ctrl.sv
// Parking meter session sequencer: buy time, freeze tariff and amount at start, count down, flag expiry.
module parking_session_ctrl
    import parking_pkg::*;
#(
    parameter int ADD_STEP_P   = ADD_STEP,
    parameter int MAX_SEC_P    = MAX_SEC,
    parameter int HOUR_LIMIT_P = HOUR_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic              btn_add,
    input  logic              btn_start,
    input  logic              btn_cancel,
    input  logic [CFG_W-1:0]  sw,
    input  logic [COST_W-1:0] cost_in,
    output logic [SEC_W-1:0]  sec_count,
    output logic [CFG_W-1:0]  sw_cfg,
    output logic [1:0]        state,
    output logic [COST_W-1:0] amount_due,
    output logic              expired,
    output logic              flash,
    output logic              err_hour
);
    localparam logic [5:0] HOUR_LIM_W = 6'(HOUR_LIMIT_P);

    state_t state_q, state_d;
    logic   t_clr, t_add, t_dec, zero_next;
    logic   cfg_load, due_load, err_d, flash_d, hour_ok;

    session_timer #(.W(SEC_W), .STEP(ADD_STEP_P), .MAX(MAX_SEC_P)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (t_clr),
        .add       (t_add),
        .dec       (t_dec),
        .count     (sec_count),
        .zero_next (zero_next)
    );

    // Hour is judged on the registered config so it matches what cost_convert saw.
    assign hour_ok = {1'b0, sw_cfg[4:0]} < HOUR_LIM_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        t_clr    = 1'b0;
        t_add    = 1'b0;
        t_dec    = 1'b0;
        cfg_load = 1'b0;
        due_load = 1'b0;
        err_d    = 1'b0;
        flash_d  = flash;
        case (state_q)
            ST_IDLE: begin
                cfg_load = 1'b1;
                if (btn_cancel) begin
                    t_clr = 1'b1;
                end else if (btn_add) begin
                    t_add   = 1'b1;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                cfg_load = 1'b1;
                if (btn_cancel) begin
                    t_clr   = 1'b1;
                    state_d = ST_IDLE;
                end else if (btn_add) begin
                    t_add = 1'b1;
                end else if (btn_start) begin
                    if (hour_ok) begin
                        due_load = 1'b1;
                        cfg_load = 1'b0;
                        state_d  = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (btn_cancel) begin
                    t_clr   = 1'b1;
                    state_d = ST_IDLE;
                end else if (tick_1hz) begin
                    t_dec = 1'b1;
                    if (zero_next) state_d = ST_EXPIRED;
                end
            end
            ST_EXPIRED: begin
                if (btn_cancel) begin
                    t_clr   = 1'b1;
                    flash_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (btn_add) begin
                    t_add   = 1'b1;
                    flash_d = 1'b0;
                    state_d = ST_SELECT;
                end else if (tick_1hz) begin
                    flash_d = ~flash;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_cfg     <= '0;
            amount_due <= '0;
            flash      <= 1'b0;
            err_hour   <= 1'b0;
        end else begin
            if (cfg_load) sw_cfg <= sw;
            if (due_load) amount_due <= cost_in;
            flash    <= flash_d;
            err_hour <= err_d;
        end
    end

    assign state   = state_q;
    assign expired = (state_q == ST_EXPIRED);
endmodule

// File: tb/tb_parking_session_ctrl.sv
// Scoreboard bench for parking_session_ctrl with a stub cost converter (5 cents per full minute).
module tb_parking_session_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_1hz = 1'b0, btn_add = 1'b0, btn_start = 1'b0, btn_cancel = 1'b0;
    logic [7:0]  sw = 8'd0;
    logic [13:0] cost_in;
    logic [11:0] sec_count;
    logic [7:0]  sw_cfg;
    logic [1:0]  state;
    logic [13:0] amount_due;
    logic        expired, flash, err_hour;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;
    exp_t sb[$];

    localparam int S_STATE = 0, S_SEC = 1, S_CFG = 2, S_DUE = 3, S_EXP = 4, S_FLASH = 5, S_ERR = 6;

    parking_session_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .btn_add    (btn_add),
        .btn_start  (btn_start),
        .btn_cancel (btn_cancel),
        .sw         (sw),
        .cost_in    (cost_in),
        .sec_count  (sec_count),
        .sw_cfg     (sw_cfg),
        .state      (state),
        .amount_due (amount_due),
        .expired    (expired),
        .flash      (flash),
        .err_hour   (err_hour)
    );

    always #5 clk = ~clk;

    assign cost_in = 14'((int'(sec_count) / 60) * 5);

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            S_STATE: return int'(state);
            S_SEC:   return int'(sec_count);
            S_CFG:   return int'(sw_cfg);
            S_DUE:   return int'(amount_due);
            S_EXP:   return int'(expired);
            S_FLASH: return int'(flash);
            default: return int'(err_hour);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.val);
        end
    endtask

    // One clock with the given pulses; outputs checked 1 ns after the edge.
    task automatic pulse(input logic a, input logic s, input logic c, input logic t);
        btn_add = a; btn_start = s; btn_cancel = c; tick_1hz = t;
        @(posedge clk); #1;
        btn_add = 0; btn_start = 0; btn_cancel = 0; tick_1hz = 0;
        drain();
    endtask

    initial begin
        // Reset state
        #2;
        push("rst_state", S_STATE, 0); push("rst_sec", S_SEC, 0); push("rst_cfg", S_CFG, 0);
        push("rst_due", S_DUE, 0); push("rst_exp", S_EXP, 0); push("rst_flash", S_FLASH, 0);
        push("rst_err", S_ERR, 0);
        drain();
        @(posedge clk); #1; rst_n = 1'b1;

        // Basic purchase: hour 9, two adds, start
        sw = 8'b011_01001;
        push("idle_start_ign", S_STATE, 0);
        pulse(0, 1, 0, 0);
        push("cfg_lag", S_CFG, 8'h69);
        pulse(0, 0, 0, 0);
        push("add1_state", S_STATE, 1); push("add1_sec", S_SEC, 300);
        pulse(1, 0, 0, 0);
        push("add2_sec", S_SEC, 600);
        pulse(1, 0, 0, 0);
        push("start_state", S_STATE, 2); push("start_due", S_DUE, 50);
        push("start_sec", S_SEC, 600); push("start_cfg", S_CFG, 8'h69);
        pulse(0, 1, 0, 0);
        sw = 8'b100_00011;
        push("run_cfg_frozen", S_CFG, 8'h69);
        pulse(0, 0, 0, 0);

        // Asynchronous reset mid-RUN
        rst_n = 1'b0; #2;
        push("arst_state", S_STATE, 0); push("arst_sec", S_SEC, 0);
        push("arst_due", S_DUE, 0); push("arst_flash", S_FLASH, 0);
        drain();
        #1; rst_n = 1'b1;

        // Saturation at 3599
        sw = 8'b001_00010;
        for (int k = 1; k <= 13; k++) begin
            push($sformatf("sat_add%0d", k), S_SEC, (300 * k > 3599) ? 3599 : 300 * k);
            pulse(1, 0, 0, 0);
        end
        push("sat_due", S_DUE, 295); push("sat_state", S_STATE, 2);
        pulse(0, 1, 0, 0);

        // Cancel beats a coincident tick in RUN
        push("cx_state", S_STATE, 0); push("cx_sec", S_SEC, 0); push("cx_due_kept", S_DUE, 295);
        pulse(0, 0, 1, 1);

        // Countdown to expiry and flash
        pulse(1, 0, 0, 0);
        push("cd_due", S_DUE, 25);
        pulse(0, 1, 0, 0);
        push("run_add_ign", S_SEC, 300); push("run_add_state", S_STATE, 2);
        pulse(1, 1, 0, 0);
        for (int i = 1; i <= 298; i++) begin
            push("cd_tick", S_SEC, 300 - i);
            pulse(0, 0, 0, 1);
        end
        push("cd_one_sec", S_SEC, 1); push("cd_one_state", S_STATE, 2);
        pulse(0, 0, 0, 1);
        push("cd_zero_sec", S_SEC, 0); push("cd_zero_state", S_STATE, 3);
        push("cd_expired", S_EXP, 1); push("cd_flash0", S_FLASH, 0);
        pulse(0, 0, 0, 1);
        push("flash_a", S_FLASH, 1); pulse(0, 0, 0, 1);
        push("flash_b", S_FLASH, 0); pulse(0, 0, 0, 1);
        push("flash_c", S_FLASH, 1); push("exp_sec", S_SEC, 0); pulse(0, 0, 0, 1);
        push("exp_hold", S_FLASH, 1); pulse(0, 0, 0, 0);

        // EXPIRED: add and cancel together -> IDLE
        push("ea_state", S_STATE, 0); push("ea_flash", S_FLASH, 0);
        push("ea_sec", S_SEC, 0); push("ea_exp", S_EXP, 0);
        pulse(1, 0, 1, 0);

        // Invalid hour refused
        sw = 8'b000_11000;
        pulse(1, 0, 0, 0);
        push("bh_err", S_ERR, 1); push("bh_state", S_STATE, 1); push("bh_due", S_DUE, 25);
        pulse(0, 1, 0, 0);
        push("bh_err_clr", S_ERR, 0); push("bh_state2", S_STATE, 1);
        pulse(0, 0, 0, 0);
        sw = 8'b010_10111;
        pulse(0, 0, 0, 0);
        push("h23_state", S_STATE, 2); push("h23_cfg", S_CFG, 8'b010_10111); push("h23_err", S_ERR, 0);
        pulse(0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
